countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter LOAD_DEFAULT, default 16'h0100, BCD mm:ss value held after reset (01:00).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of flip-flops in each divided-clock synchronizer (minimum 2).
REQ-003 SHALL have port clock_i, input, 1, system clock (100 MHz); one clock only.
REQ-004 SHALL have port reset_i, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port clock_1Hz_i, input, 1, divided 1 Hz square wave from the clock divider.
REQ-006 SHALL have port clock_2Hz_i, input, 1, divided 2 Hz square wave from the clock divider.
REQ-007 SHALL have port load_i, input, 1, single-cycle request to load load_bcd_i.
REQ-008 SHALL have port load_bcd_i, input, 16, BCD digits {min_tens, min_ones, sec_tens, sec_ones}.
REQ-009 SHALL have port start_i, input, 1, single-cycle start/resume request.
REQ-010 SHALL have port pause_i, input, 1, single-cycle pause request.
REQ-011 SHALL have port digits_o, output, 16, current BCD mm:ss, same digit order as load_bcd_i.
REQ-012 SHALL have port running_o, output, 1, high while in state RUN.
REQ-013 SHALL have port expired_o, output, 1, high while in state EXPIRED.
REQ-014 SHALL have port blink_o, output, 1, synchronized 2 Hz level while EXPIRED, else 0.

Function
REQ-015 SHALL pass clock_1Hz_i and clock_2Hz_i through SYNC_STAGES flip-flops each before any use.
REQ-016 SHALL generate internal one-cycle tick on the rising edge of synchronized clock_1Hz_i; the count update becomes visible on digits_o at the clock_i edge SYNC_STAGES+1 edges after the first edge sampling clock_1Hz_i high.
REQ-017 SHALL implement states IDLE, RUN, PAUSE, EXPIRED; all outputs registered.
REQ-018 SHALL on load_i, in any state, go to IDLE and load clamped load_bcd_i; load_i has priority over start_i, pause_i and tick in the same cycle.
REQ-019 SHALL clamp on load: any ones digit >9 to 9, any tens digit >5 to 5 (max 59:59).
REQ-020 SHALL go IDLE->RUN on start_i when digits_o != 0000; start_i with 0000 leaves state IDLE.
REQ-021 SHALL go RUN->PAUSE on pause_i; pause_i wins over start_i and over a coincident tick (no decrement that cycle).
REQ-022 SHALL go PAUSE->RUN on start_i only when pause_i is low; ticks during PAUSE and IDLE are discarded.
REQ-023 SHALL decrement in RUN by one second per tick with BCD borrow: sec_ones 0->9 borrows sec_tens, sec_tens 0->5 borrows min_ones, min_ones 0->9 borrows min_tens.
REQ-024 SHALL on a tick in RUN with digits_o == 0001 write 0000 and enter EXPIRED in the same cycle; never wrap below 0000.
REQ-025 SHALL remain in EXPIRED, ignoring start_i, pause_i and ticks, until load_i or reset_i.

Reset
REQ-026 SHALL on reset_i high at a clock_i edge set state IDLE, digits_o = clamped LOAD_DEFAULT, running_o = 0, expired_o = 0, blink_o = 0, and clear all synchronizer and edge flops.
REQ-027 SHALL let reset_i override load_i, start_i, pause_i and tick, including mid-count in RUN.

Structure
REQ-028 SHALL place the state enumeration, BCD digit width (4), and clamp limits (9, 5) in shared package countdown_pkg.
REQ-029 SHALL use one sub-module, tick_sync (SYNC_STAGES synchronizer + rising-edge pulse, outputs level and pulse), instantiated for each divided clock.

Verification
REQ-030 SHALL test reset then start_i with no ticks -> digits_o = 16'h0100, running_o = 1 after one cycle.
REQ-031 SHALL test load 16'h1000, start, one 1 Hz rise -> digits_o = 16'h0959 exactly SYNC_STAGES+1 edges after the rise.
REQ-032 SHALL test load 16'h0002, start, two rises -> 0001 then 0000, expired_o = 1, running_o = 0, blink_o follows clock_2Hz_i (after sync delay); further rises leave 0000.
REQ-033 SHALL test load 16'hFFFF -> digits_o = 16'h5959; load 0000 plus start -> remains IDLE.
REQ-034 SHALL test pause_i coincident with tick in RUN at 0030 -> PAUSE, digits stay 0030; start_i+pause_i in PAUSE -> stays PAUSE; start_i alone -> RUN.
REQ-035 SHALL test reset_i asserted in RUN at 0517 -> next edge digits_o = 0100, IDLE, all flags 0.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types, digit limits and BCD helpers for the mm:ss countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam int DIGIT_W = 4;
  localparam int TIME_W  = 4 * DIGIT_W;
  localparam logic [DIGIT_W-1:0] ONES_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] TENS_MAX = 4'd5;

  function automatic logic [TIME_W-1:0] clamp_bcd(input logic [TIME_W-1:0] v);
    logic [TIME_W-1:0] r;
    r[15:12] = (v[15:12] > TENS_MAX) ? TENS_MAX : v[15:12];
    r[11:8]  = (v[11:8]  > ONES_MAX) ? ONES_MAX : v[11:8];
    r[7:4]   = (v[7:4]   > TENS_MAX) ? TENS_MAX : v[7:4];
    r[3:0]   = (v[3:0]   > ONES_MAX) ? ONES_MAX : v[3:0];
    return r;
  endfunction

  // One-second decrement with borrow; callers never pass 00:00.
  function automatic logic [TIME_W-1:0] bcd_dec(input logic [TIME_W-1:0] v);
    logic [DIGIT_W-1:0] d3, d2, d1, d0;
    {d3, d2, d1, d0} = v;
    if (d0 != 4'd0) begin
      d0 = d0 - 4'd1;
    end else begin
      d0 = ONES_MAX;
      if (d1 != 4'd0) begin
        d1 = d1 - 4'd1;
      end else begin
        d1 = TENS_MAX;
        if (d2 != 4'd0) begin
          d2 = d2 - 4'd1;
        end else begin
          d2 = ONES_MAX;
          if (d3 != 4'd0) begin
            d3 = d3 - 4'd1;
          end else begin
            d3 = 4'd0;
          end
        end
      end
    end
    return {d3, d2, d1, d0};
  endfunction

endpackage

// File: rtl/tick_sync.sv
// Synchronizes a slow divided clock into the system domain and flags its rising edge.
module tick_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], raw};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign level = sync_r[STAGES-1];
  assign pulse = sync_r[STAGES-1] & ~prev_r;

endmodule

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer with load/start/pause control and a blinking expiry indication.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter logic [15:0] LOAD_DEFAULT = 16'h0100,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        clock_1Hz_i,
  input  logic        clock_2Hz_i,
  input  logic        load_i,
  input  logic [15:0] load_bcd_i,
  input  logic        start_i,
  input  logic        pause_i,
  output logic [15:0] digits_o,
  output logic        running_o,
  output logic        expired_o,
  output logic        blink_o
);

  localparam logic [TIME_W-1:0] RESET_DIGITS = clamp_bcd(LOAD_DEFAULT);

  state_t            state_r, state_next;
  logic [TIME_W-1:0] digits_r, digits_next;
  logic              running_r, expired_r, blink_r;
  logic              running_next, expired_next, blink_next;
  logic              sec_level_unused, sec_tick;
  logic              blink_level, blink_pulse_unused;

  tick_sync #(.STAGES(SYNC_STAGES)) u_sync_1hz (
    .clk   (clock_i),
    .rst   (reset_i),
    .raw   (clock_1Hz_i),
    .level (sec_level_unused),
    .pulse (sec_tick)
  );

  tick_sync #(.STAGES(SYNC_STAGES)) u_sync_2hz (
    .clk   (clock_i),
    .rst   (reset_i),
    .raw   (clock_2Hz_i),
    .level (blink_level),
    .pulse (blink_pulse_unused)
  );

  // Next state and count; load always wins, pause beats a coincident tick
  always_comb begin
    state_next  = state_r;
    digits_next = digits_r;
    if (load_i) begin
      state_next  = IDLE;
      digits_next = clamp_bcd(load_bcd_i);
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i && (digits_r != 16'h0000)) begin
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
        end
        RUN: begin
          if (pause_i) begin
            state_next = PAUSE;
          end else if (sec_tick) begin
            if (digits_r <= 16'h0001) begin
              digits_next = 16'h0000;
              state_next  = EXPIRED;
            end else begin
              digits_next = bcd_dec(digits_r);
            end
          end else begin
            state_next = RUN;
          end
        end
        PAUSE: begin
          if (start_i && !pause_i) begin
            state_next = RUN;
          end else begin
            state_next = PAUSE;
          end
        end
        EXPIRED: state_next = EXPIRED;
        default: state_next = IDLE;
      endcase
    end
    running_next = (state_next == RUN);
    expired_next = (state_next == EXPIRED);
    blink_next   = expired_next & blink_level;
  end

  // State, count and flag registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_r   <= IDLE;
      digits_r  <= RESET_DIGITS;
      running_r <= 1'b0;
      expired_r <= 1'b0;
      blink_r   <= 1'b0;
    end else begin
      state_r   <= state_next;
      digits_r  <= digits_next;
      running_r <= running_next;
      expired_r <= expired_next;
      blink_r   <= blink_next;
    end
  end

  assign digits_o  = digits_r;
  assign running_o = running_r;
  assign expired_o = expired_r;
  assign blink_o   = blink_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: expectations queued with stimulus, observations queued on sampling.
module tb_countdown_timer;

  localparam int S = 2;

  logic        clock_i     = 1'b0;
  logic        reset_i     = 1'b1;
  logic        clock_1Hz_i = 1'b0;
  logic        clock_2Hz_i = 1'b0;
  logic        load_i      = 1'b0;
  logic [15:0] load_bcd_i  = 16'h0000;
  logic        start_i     = 1'b0;
  logic        pause_i     = 1'b0;
  logic [15:0] digits_o;
  logic        running_o, expired_o, blink_o;

  typedef struct {
    string       name;
    logic [18:0] v;
  } ent_t;

  ent_t exp_q[$];
  ent_t obs_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  countdown_timer #(.LOAD_DEFAULT(16'h0100), .SYNC_STAGES(S)) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .clock_1Hz_i (clock_1Hz_i),
    .clock_2Hz_i (clock_2Hz_i),
    .load_i      (load_i),
    .load_bcd_i  (load_bcd_i),
    .start_i     (start_i),
    .pause_i     (pause_i),
    .digits_o    (digits_o),
    .running_o   (running_o),
    .expired_o   (expired_o),
    .blink_o     (blink_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock_i);
      #1;
    end
  endtask

  // Queue the expected outputs, run n edges, then queue what the DUT shows.
  task automatic expect_after(input string name, input logic [15:0] d, input logic r,
                              input logic e, input logic b, input int n);
    ent_t x;
    x.name = name;
    x.v    = {d, r, e, b};
    exp_q.push_back(x);
    cyc(n);
    x.v = {digits_o, running_o, expired_o, blink_o};
    obs_q.push_back(x);
  endtask

  task automatic do_load(input string name, input logic [15:0] v, input logic [15:0] d);
    load_bcd_i = v;
    load_i     = 1'b1;
    expect_after(name, d, 1'b0, 1'b0, 1'b0, 1);
    load_i     = 1'b0;
  endtask

  task automatic fall_1hz();
    clock_1Hz_i = 1'b0;
    cyc(S + 2);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    expect_after("reset_state", 16'h0100, 1'b0, 1'b0, 1'b0, 1);
    reset_i = 1'b0;
    while (exp_q.size() > 0) begin
      ent_t e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: no observation recorded", e.name);
      end else begin
        o = obs_q.pop_front();
        if (o.v !== e.v) begin
          n_fail++;
          $display("FAIL %s: got digits=%h run=%b exp=%b blink=%b, expected digits=%h run=%b exp=%b blink=%b",
                   e.name, o.v[18:3], o.v[2], o.v[1], o.v[0], e.v[18:3], e.v[2], e.v[1], e.v[0]);
        end
      end
    end
  endtask

  task automatic test_start_no_tick();
    start_i = 1'b1;
    expect_after("start_default", 16'h0100, 1'b1, 1'b0, 1'b0, 1);
    start_i = 1'b0;
    expect_after("run_no_tick", 16'h0100, 1'b1, 1'b0, 1'b0, 4);
    while (exp_q.size() > 0) begin
      ent_t e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: no observation recorded", e.name);
      end else begin
        o = obs_q.pop_front();
        if (o.v !== e.v) begin
          n_fail++;
          $display("FAIL %s: got digits=%h run=%b exp=%b blink=%b, expected digits=%h run=%b exp=%b blink=%b",
                   e.name, o.v[18:3], o.v[2], o.v[1], o.v[0], e.v[18:3], e.v[2], e.v[1], e.v[0]);
        end
      end
    end
  endtask

  task automatic test_borrow();
    logic [15:0] ld [5];
    logic [15:0] ex [5];
    ld = '{16'h1000, 16'h0010, 16'h0520, 16'h2300, 16'h0100};
    ex = '{16'h0959, 16'h0009, 16'h0519, 16'h2259, 16'h0059};
    for (int i = 0; i < 5; i++) begin
      do_load($sformatf("load_%h", ld[i]), ld[i], ld[i]);
      start_i = 1'b1;
      expect_after($sformatf("start_%h", ld[i]), ld[i], 1'b1, 1'b0, 1'b0, 1);
      start_i = 1'b0;
      clock_1Hz_i = 1'b1;
      expect_after($sformatf("pre_tick_%h", ld[i]), ld[i], 1'b1, 1'b0, 1'b0, S);
      expect_after($sformatf("dec_%h", ld[i]), ex[i], 1'b1, 1'b0, 1'b0, 1);
      fall_1hz();
    end
    while (exp_q.size() > 0) begin
      ent_t e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: no observation recorded", e.name);
      end else begin
        o = obs_q.pop_front();
        if (o.v !== e.v) begin
          n_fail++;
          $display("FAIL %s: got digits=%h run=%b exp=%b blink=%b, expected digits=%h run=%b exp=%b blink=%b",
                   e.name, o.v[18:3], o.v[2], o.v[1], o.v[0], e.v[18:3], e.v[2], e.v[1], e.v[0]);
        end
      end
    end
  endtask

  task automatic test_expire();
    clock_2Hz_i = 1'b0;
    do_load("exp_load", 16'h0002, 16'h0002);
    start_i = 1'b1;
    expect_after("exp_start", 16'h0002, 1'b1, 1'b0, 1'b0, 1);
    start_i = 1'b0;
    clock_1Hz_i = 1'b1;
    expect_after("exp_first_tick", 16'h0001, 1'b1, 1'b0, 1'b0, S + 1);
    fall_1hz();
    clock_1Hz_i = 1'b1;
    expect_after("exp_reach_zero", 16'h0000, 1'b0, 1'b1, 1'b0, S + 1);
    fall_1hz();
    clock_2Hz_i = 1'b1;
    expect_after("blink_sync_delay", 16'h0000, 1'b0, 1'b1, 1'b0, S);
    expect_after("blink_high", 16'h0000, 1'b0, 1'b1, 1'b1, 1);
    clock_2Hz_i = 1'b0;
    expect_after("blink_low", 16'h0000, 1'b0, 1'b1, 1'b0, S + 1);
    start_i = 1'b1;
    expect_after("exp_ignore_start", 16'h0000, 1'b0, 1'b1, 1'b0, 1);
    start_i = 1'b0;
    clock_1Hz_i = 1'b1;
    expect_after("exp_no_wrap", 16'h0000, 1'b0, 1'b1, 1'b0, S + 1);
    fall_1hz();
    do_load("exp_exit_load", 16'h0100, 16'h0100);
    while (exp_q.size() > 0) begin
      ent_t e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: no observation recorded", e.name);
      end else begin
        o = obs_q.pop_front();
        if (o.v !== e.v) begin
          n_fail++;
          $display("FAIL %s: got digits=%h run=%b exp=%b blink=%b, expected digits=%h run=%b exp=%b blink=%b",
                   e.name, o.v[18:3], o.v[2], o.v[1], o.v[0], e.v[18:3], e.v[2], e.v[1], e.v[0]);
        end
      end
    end
  endtask

  task automatic test_clamp();
    do_load("clamp_ffff", 16'hFFFF, 16'h5959);
    do_load("clamp_0a6b", 16'h0A6B, 16'h0959);
    do_load("load_zero", 16'h0000, 16'h0000);
    start_i = 1'b1;
    expect_after("start_at_zero", 16'h0000, 1'b0, 1'b0, 1'b0, 1);
    start_i = 1'b0;
    do_load("idle_load", 16'h0100, 16'h0100);
    clock_1Hz_i = 1'b1;
    expect_after("idle_tick_ignored", 16'h0100, 1'b0, 1'b0, 1'b0, S + 1);
    fall_1hz();
    start_i = 1'b1;
    do_load("load_beats_start", 16'h0300, 16'h0300);
    start_i = 1'b0;
    while (exp_q.size() > 0) begin
      ent_t e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: no observation recorded", e.name);
      end else begin
        o = obs_q.pop_front();
        if (o.v !== e.v) begin
          n_fail++;
          $display("FAIL %s: got digits=%h run=%b exp=%b blink=%b, expected digits=%h run=%b exp=%b blink=%b",
                   e.name, o.v[18:3], o.v[2], o.v[1], o.v[0], e.v[18:3], e.v[2], e.v[1], e.v[0]);
        end
      end
    end
  endtask

  task automatic test_pause();
    do_load("pause_load", 16'h0030, 16'h0030);
    start_i = 1'b1;
    expect_after("pause_start", 16'h0030, 1'b1, 1'b0, 1'b0, 1);
    start_i = 1'b0;
    clock_1Hz_i = 1'b1;
    expect_after("pause_pre_tick", 16'h0030, 1'b1, 1'b0, 1'b0, S);
    pause_i = 1'b1;
    expect_after("pause_wins_tick", 16'h0030, 1'b0, 1'b0, 1'b0, 1);
    pause_i = 1'b0;
    fall_1hz();
    clock_1Hz_i = 1'b1;
    expect_after("pause_tick_ignored", 16'h0030, 1'b0, 1'b0, 1'b0, S + 1);
    fall_1hz();
    start_i = 1'b1;
    pause_i = 1'b1;
    expect_after("pause_start_and_pause", 16'h0030, 1'b0, 1'b0, 1'b0, 1);
    pause_i = 1'b0;
    expect_after("pause_resume", 16'h0030, 1'b1, 1'b0, 1'b0, 1);
    start_i = 1'b0;
    clock_1Hz_i = 1'b1;
    expect_after("resume_counts", 16'h0029, 1'b1, 1'b0, 1'b0, S + 1);
    fall_1hz();
    while (exp_q.size() > 0) begin
      ent_t e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: no observation recorded", e.name);
      end else begin
        o = obs_q.pop_front();
        if (o.v !== e.v) begin
          n_fail++;
          $display("FAIL %s: got digits=%h run=%b exp=%b blink=%b, expected digits=%h run=%b exp=%b blink=%b",
                   e.name, o.v[18:3], o.v[2], o.v[1], o.v[0], e.v[18:3], e.v[2], e.v[1], e.v[0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    do_load("rst_load", 16'h0517, 16'h0517);
    start_i = 1'b1;
    expect_after("rst_start", 16'h0517, 1'b1, 1'b0, 1'b0, 1);
    reset_i = 1'b1;
    pause_i = 1'b1;
    load_bcd_i = 16'h0444;
    load_i = 1'b1;
    expect_after("reset_overrides", 16'h0100, 1'b0, 1'b0, 1'b0, 1);
    reset_i = 1'b0;
    pause_i = 1'b0;
    load_i  = 1'b0;
    start_i = 1'b0;
    expect_after("reset_idle_hold", 16'h0100, 1'b0, 1'b0, 1'b0, 2);
    while (exp_q.size() > 0) begin
      ent_t e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: no observation recorded", e.name);
      end else begin
        o = obs_q.pop_front();
        if (o.v !== e.v) begin
          n_fail++;
          $display("FAIL %s: got digits=%h run=%b exp=%b blink=%b, expected digits=%h run=%b exp=%b blink=%b",
                   e.name, o.v[18:3], o.v[2], o.v[1], o.v[0], e.v[18:3], e.v[2], e.v[1], e.v[0]);
        end
      end
    end
  endtask

  initial begin
    cyc(2);
    test_reset();
    test_start_no_tick();
    test_borrow();
    test_expire();
    test_clamp();
    test_pause();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
